// File: rtl/subtractor4_serial.sv
// ============================================================================
// Module   : subtractor4_serial
// Brief    : Nibble-serial WIDTH-bit subtractor (a - b - borrow), one 4-bit
//            carry-lookahead stage per clock, LSB nibble first.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module subtractor4_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_valid;

    logic [CW+1:0]    w_base;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_nb_nib;
    logic [3:0]       w_p;
    logic [3:0]       w_g;
    logic [4:0]       w_c;
    logic [3:0]       w_sum;
    logic             w_accept;
    logic             w_last;

    // ------------------------------------------------------------------------
    // Nibble stage: a + ~b + carry through a 4-bit carry-lookahead.
    // ------------------------------------------------------------------------
    always_comb begin
        w_base   = {r_cnt, 2'b00};
        w_a_nib  = r_a[w_base +: 4];
        w_nb_nib = ~r_b[w_base +: 4];
        w_p      = w_a_nib ^ w_nb_nib;
        w_g      = w_a_nib & w_nb_nib;
        w_c[0]   = r_carry;
        w_c[1]   = w_g[0] | (w_p[0] & r_carry);
        w_c[2]   = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3]   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c[4]   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_sum    = w_p ^ w_c[3:0];
    end

    assign ready_o  = (r_state == IDLE) && !rst_i;
    assign w_accept = valid_i && ready_o;
    assign w_last   = (r_cnt == C_LAST);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = CALC;
            CALC:    if (w_last)   w_state_nxt = DONE;
            DONE:    if (ready_i)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand capture, registered carry chain, result flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_carry <= ~borrow_i;
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_diff[w_base +: 4] <= w_sum;
                    r_carry             <= w_c[4];
                    r_cnt               <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Final carry out of a + ~b + 1 is the inverse of the borrow.
                        r_borrow <= ~w_c[4];
                        r_ovf    <= (r_a[WIDTH-1] != r_b[WIDTH-1])
                                 && (w_sum[3] != r_a[WIDTH-1]);
                        r_valid  <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign valid_o    = r_valid;
    assign diff_o     = r_diff;
    assign borrow_o   = r_borrow;
    assign overflow_o = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_subtractor4_serial.sv
// ============================================================================
// Module   : tb_subtractor4_serial
// Brief    : Scoreboard bench for subtractor4_serial at WIDTH=16.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_subtractor4_serial;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             borrow_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;
    logic             overflow_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    subtractor4_serial #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .borrow_i   (borrow_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .diff_o     (diff_o),
        .borrow_o   (borrow_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin);
        exp_t e;
        int   ia;
        int   ib;
        ia       = int'(a);
        ib       = int'(b);
        e.diff   = WIDTH'(ia - ib - int'(bin));
        e.borrow = (ia - ib - int'(bin)) < 0;
        e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Present operands, wait for acceptance, push expectation.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        int guard;
        @(negedge clk_i);
        a_i      = a;
        b_i      = b;
        borrow_i = bin;
        valid_i  = 1'b1;
        guard    = 0;
        while (!ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check("accept_timeout", 32'(guard >= 20), 32'd0);
        @(posedge clk_i);
        sb_q.push_back(model(a, b, bin));
        #1;
        valid_i  = 1'b0;
        a_i      = WIDTH'($urandom);
        b_i      = WIDTH'($urandom);
        borrow_i = 1'($urandom);
    endtask

    // Wait for valid_o, check latency and scoreboard entry.
    task automatic collect(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (valid_o) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NIB));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_diff"},   32'(diff_o),     32'(e.diff));
            check({tag, "_borrow"}, 32'(borrow_o),   32'(e.borrow));
            check({tag, "_ovf"},    32'(overflow_o), 32'(e.ovf));
        end
        check({tag, "_ready_in_done"}, 32'(ready_o), 32'd0);
    endtask

    task automatic op(input string tag, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic bin);
        ready_i = 1'b1;
        send(a, b, bin);
        collect(tag);
        @(posedge clk_i);
        #1;
        check({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
        check({tag, "_ready_back"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] hold_diff;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;
        borrow_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready",  32'(ready_o),    32'd0);
        check("rst_valid",  32'(valid_o),    32'd0);
        check("rst_diff",   32'(diff_o),     32'd0);
        check("rst_borrow", 32'(borrow_o),   32'd0);
        check("rst_ovf",    32'(overflow_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("idle_ready", 32'(ready_o), 32'd1);

        op("t1", 16'h1234, 16'h0234, 1'b0);
        op("t2", 16'h0000, 16'h0001, 1'b0);
        op("t3a", 16'h8000, 16'h0001, 1'b0);
        op("t3b", 16'h7FFF, 16'hFFFF, 1'b0);
        op("t4", 16'h0005, 16'h0005, 1'b1);

        // Backpressure in DONE with new operands offered.
        ready_i = 1'b0;
        send(16'hABCD, 16'h1111, 1'b0);
        collect("t5");
        hold_diff = diff_o;
        @(negedge clk_i);
        valid_i  = 1'b1;
        a_i      = 16'h0F0F;
        b_i      = 16'h0101;
        borrow_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("t5_hold_valid", 32'(valid_o), 32'd1);
            check("t5_hold_diff",  32'(diff_o),  32'(hold_diff));
            check("t5_hold_ready", 32'(ready_o), 32'd0);
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("t5_release_valid", 32'(valid_o), 32'd0);
        check("t5_release_ready", 32'(ready_o), 32'd1);
        op("t5_next", 16'h0F0F, 16'h0101, 1'b1);

        // Reset during the second CALC cycle.
        send(16'h5555, 16'h1234, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        check("t6_valid",  32'(valid_o),    32'd0);
        check("t6_diff",   32'(diff_o),     32'd0);
        check("t6_borrow", 32'(borrow_o),   32'd0);
        check("t6_ovf",    32'(overflow_o), 32'd0);
        check("t6_ready_in_rst", 32'(ready_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("t6_ready_after", 32'(ready_o), 32'd1);
        op("t6_next", 16'h00FF, 16'h000F, 1'b0);

        for (int i = 0; i < 12; i++) begin
            op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
